// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// The 16-bit packed BCD input {d3,d2,d1,d0} is captured once per frame, at the
// last cycle of digit slot 3. This means a value that changes mid-scan never
// shows torn digits. Each digit slot lasts REFRESH_DIV cycles. The first cycle
// of every slot is a blank "ghost gap" so the previous digit's segments do not
// bleed onto the next anode while the lines settle.
//
// Optional feature:
//   SEG7_LZ_BLANK_EN  - when defined, leading zeros are blanked (digit 0 is
//                       never blanked; a dash nibble counts as non-zero).
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//
// Ports:
//   clock    in   1   system clock, rising edge
//   reset    in   1   asynchronous, active-high; clears all state
//   decimal  in  16   packed BCD {d3,d2,d1,d0}
//   anode    out  4   active-low digit enables, anode[i] selects digit i
//   segment  out  7   active-low {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] decimal,
  output logic [3:0]  anode,
  output logic [6:0]  segment
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low gfedcba encoding; anything above 9 renders as a dash.
  function automatic logic [6:0] f_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [15:0]   r_latch;
  logic [3:0]    r_anode_p1;
  logic [6:0]    r_segment_p1;

  logic          w_tick;
  logic [3:0]    w_digit;
  logic [3:0]    w_blank;
  logic [3:0]    w_anode_nxt;
  logic [6:0]    w_segment_nxt;

  assign w_tick  = (r_presc == PRESC_LAST);
  assign w_digit = r_latch[{r_idx, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero.
  logic [3:0] w_nz;
  assign w_nz[0] = (r_latch[3:0]   != 4'd0);
  assign w_nz[1] = (r_latch[7:4]   != 4'd0);
  assign w_nz[2] = (r_latch[11:8]  != 4'd0);
  assign w_nz[3] = (r_latch[15:12] != 4'd0);
  assign w_blank[3] = ~w_nz[3];
  assign w_blank[2] = ~w_nz[3] & ~w_nz[2];
  assign w_blank[1] = ~w_nz[3] & ~w_nz[2] & ~w_nz[1];
  assign w_blank[0] = 1'b0;
  logic w_unused_nz0;
  assign w_unused_nz0 = w_nz[0];
`else
  assign w_blank = 4'b0000;
`endif

  // Next pin values; the first cycle of each slot is the ghost gap.
  always_comb begin
    w_anode_nxt   = 4'b1111;
    w_segment_nxt = SEG_BLANK;
    if (r_presc != '0) begin
      w_anode_nxt   = ~(4'b0001 << r_idx);
      w_segment_nxt = w_blank[r_idx] ? SEG_BLANK : f_encode(w_digit);
    end
  end

  // Stage p0: scan state and frame latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
      r_latch <= 16'h0000;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
        // Capture only at the frame boundary so one frame is always coherent.
        if (r_idx == 2'd3) begin
          r_latch <= decimal;
        end
      end
    end
  end

  // Stage p1: registered pins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_anode_p1   <= 4'b1111;
      r_segment_p1 <= SEG_BLANK;
    end else begin
      r_anode_p1   <= w_anode_nxt;
      r_segment_p1 <= w_segment_nxt;
    end
  end

  assign anode   = r_anode_p1;
  assign segment = r_segment_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int RDIV = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] decimal = 16'h0000;
  logic [3:0]  anode;
  logic [6:0]  segment;

  int checks   = 0;
  int failures = 0;
  int frame_no = 0;

  seg7_scan_driver #(.REFRESH_DIV(RDIV)) dut (
    .clock   (clock),
    .reset   (reset),
    .decimal (decimal),
    .anode   (anode),
    .segment (segment)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] dec;
    logic [6:0]  s3;
    logic [6:0]  s2;
    logic [6:0]  s1;
    logic [6:0]  s0;
  } vec_t;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  // Expected {anode, segment} per edge, pushed per frame, popped per edge.
  logic [10:0] exp_q[$];

  function automatic vec_t mk(input logic [15:0] dec,
                              input logic [6:0] a3, input logic [6:0] a2,
                              input logic [6:0] a1, input logic [6:0] a0,
                              input logic [6:0] b3, input logic [6:0] b2,
                              input logic [6:0] b1, input logic [6:0] b0);
    vec_t v;
    v.dec = dec;
`ifdef SEG7_LZ_BLANK_EN
    v.s3 = b3; v.s2 = b2; v.s1 = b1; v.s0 = b0;
`else
    v.s3 = a3; v.s2 = a2; v.s1 = a1; v.s0 = a0;
`endif
    return v;
  endfunction

  function automatic logic [6:0] seg_of(input vec_t v, input int i);
    case (i)
      0:       return v.s0;
      1:       return v.s1;
      2:       return v.s2;
      default: return v.s3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [3:0] ga, input logic [6:0] gs,
                     input logic [3:0] ea, input logic [6:0] es);
    checks++;
    if (ga !== ea || gs !== es) begin
      failures++;
      $display("FAIL %s anode=%b segment=%b expected anode=%b segment=%b",
               nm, ga, gs, ea, es);
    end
  endtask

  // Runs one 4-slot frame whose latch should hold v. Drives a junk value at
  // the start of the frame and the next value while idx==1; only the value
  // present at the frame-ending tick may be captured.
  task automatic run_frame(input vec_t v, input logic [15:0] junk,
                           input logic [15:0] nextdec);
    logic [3:0]  an;
    logic [10:0] e;
    for (int i = 0; i < 4; i++) begin
      an = ~(4'b0001 << i);
      exp_q.push_back({4'b1111, B});
      for (int c = 1; c < RDIV; c++) exp_q.push_back({an, seg_of(v, i)});
    end
    decimal = junk;
    for (int k = 1; k <= 4 * RDIV; k++) begin
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL f%0d_e%0d scoreboard empty anode=%b segment=%b",
                 frame_no, k, anode, segment);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("f%0d_e%0d", frame_no, k), anode, segment, e[10:7], e[6:0]);
      end
      if (k == RDIV + 1) decimal = nextdec;
    end
    frame_no++;
  endtask

  vec_t vecs[8];
  vec_t zero_v;
  vec_t v0a05;

  initial begin
    zero_v  = mk(16'h0000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
                 B, B, B, 7'b1000000);
    vecs[0] = mk(16'h1234, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);
    vecs[1] = mk(16'h5678, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000);
    vecs[2] = mk(16'h0007, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000,
                 B, B, B, 7'b1111000);
    vecs[3] = mk(16'h0A05, 7'b1000000, DS, 7'b1000000, 7'b0010010,
                 B, DS, 7'b1000000, 7'b0010010);
    vecs[4] = mk(16'h9999, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000,
                 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);
    vecs[5] = mk(16'h0100, 7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000,
                 B, 7'b1111001, 7'b1000000, 7'b1000000);
    vecs[6] = mk(16'hF0F0, DS, 7'b1000000, DS, 7'b1000000,
                 DS, 7'b1000000, DS, 7'b1000000);
    vecs[7] = zero_v;
    v0a05   = vecs[3];

    // Reset state.
    decimal = 16'h1234;
    #1 reset = 1'b1;
    #1 chk("reset_state", anode, segment, 4'b1111, B);
    #20 reset = 1'b0;

    // Frame 0 shows latch 0; each later frame shows the previous entry.
    run_frame(zero_v, 16'hDEAD, vecs[0].dec);
    for (int j = 0; j < 8; j++) begin
      run_frame(vecs[j], 16'hBEEF, (j < 7) ? vecs[j + 1].dec : 16'h4321);
    end

    // Reset mid-slot with idx==2, presc==1.
    repeat (2 * RDIV + 1) @(posedge clock);
    #4 reset = 1'b1;
    #1 chk("reset_async", anode, segment, 4'b1111, B);
    @(posedge clock);
    #1 chk("reset_held", anode, segment, 4'b1111, B);
    #3 reset = 1'b0;
    run_frame(zero_v, 16'h0A05, 16'h0A05);
    run_frame(v0a05, 16'h0A05, 16'h0A05);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
